// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with registered read data.
// Optional sticky overflow/underflow flags are enabled with `define FIFO_CTRL_ERR_EN.
module fifo_ctrl #(
    parameter int DATA = 16,
    parameter int ADDR = 5
) (
    input  logic              clK,
    input  logic              rst_N,
    input  logic              fifo_WR,
    input  logic [DATA-1:0]   fifo_IN,
    input  logic              fifo_RD,
    output logic [DATA-1:0]   fifo_OUT,
    output logic              fifo_VALID,
    output logic              fifo_FULL,
    output logic              fifo_EMPTY,
    output logic [ADDR:0]     fifo_COUNT,
    output logic              ram_a_WR,
    output logic [ADDR-1:0]   ram_a_ADDR,
    output logic [DATA-1:0]   ram_a_data_IN,
    output logic              ram_b_WR,
    output logic [ADDR-1:0]   ram_b_ADDR,
    output logic [DATA-1:0]   ram_b_data_IN,
    input  logic [DATA-1:0]   ram_b_data_OUT
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic              fifo_OVF,
    output logic              fifo_UDF
`endif
);

    localparam int PW = ADDR + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d;
    logic          push_ok, pop_ok;
    logic          full, empty;

    // One extra pointer bit distinguishes full from empty when the address bits match.
    assign full    = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                     (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = fifo_WR && !full;
    assign pop_ok  = fifo_RD && !empty;

    assign fifo_FULL  = full;
    assign fifo_EMPTY = empty;
    assign fifo_COUNT = wr_ptr_q - rd_ptr_q;
    assign fifo_VALID = valid_q;
    assign fifo_OUT   = ram_b_data_OUT;

    // The RAM write strobe is held off during reset so nothing is stored while in reset.
    assign ram_a_WR      = push_ok && rst_N;
    assign ram_a_ADDR    = wr_ptr_q[ADDR-1:0];
    assign ram_a_data_IN = fifo_IN;
    assign ram_b_WR      = 1'b0;
    assign ram_b_ADDR    = rd_ptr_q[ADDR-1:0];
    assign ram_b_data_IN = '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = pop_ok;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q || (fifo_WR && full);
        udf_d = udf_q || (fifo_RD && empty);
    end

    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign fifo_OVF = ovf_q;
    assign fifo_UDF = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural dual-port RAM (1-cycle registered read).
module tb_fifo_ctrl;

    localparam int DATA = 16;
    localparam int ADDR = 5;

    logic            clK;
    logic            rst_N;
    logic            fifo_WR;
    logic [DATA-1:0] fifo_IN;
    logic            fifo_RD;
    logic [DATA-1:0] fifo_OUT;
    logic            fifo_VALID;
    logic            fifo_FULL;
    logic            fifo_EMPTY;
    logic [ADDR:0]   fifo_COUNT;
    logic            ram_a_WR;
    logic [ADDR-1:0] ram_a_ADDR;
    logic [DATA-1:0] ram_a_data_IN;
    logic            ram_b_WR;
    logic [ADDR-1:0] ram_b_ADDR;
    logic [DATA-1:0] ram_b_data_IN;
    logic [DATA-1:0] ram_b_data_OUT;
`ifdef FIFO_CTRL_ERR_EN
    logic            fifo_OVF;
    logic            fifo_UDF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clK            (clK),
        .rst_N          (rst_N),
        .fifo_WR        (fifo_WR),
        .fifo_IN        (fifo_IN),
        .fifo_RD        (fifo_RD),
        .fifo_OUT       (fifo_OUT),
        .fifo_VALID     (fifo_VALID),
        .fifo_FULL      (fifo_FULL),
        .fifo_EMPTY     (fifo_EMPTY),
        .fifo_COUNT     (fifo_COUNT),
        .ram_a_WR       (ram_a_WR),
        .ram_a_ADDR     (ram_a_ADDR),
        .ram_a_data_IN  (ram_a_data_IN),
        .ram_b_WR       (ram_b_WR),
        .ram_b_ADDR     (ram_b_ADDR),
        .ram_b_data_IN  (ram_b_data_IN),
        .ram_b_data_OUT (ram_b_data_OUT)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .fifo_OVF       (fifo_OVF),
        .fifo_UDF       (fifo_UDF)
`endif
    );

    logic [DATA-1:0] mem [2**ADDR];

    always @(posedge clK) begin
        if (ram_a_WR) mem[ram_a_ADDR] <= ram_a_data_IN;
        ram_b_data_OUT <= mem[ram_b_ADDR];
    end

    initial clK = 1'b0;
    always #5 clK = ~clK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then return 1 time unit after the rising edge.
    task automatic step(input logic wr, input logic [DATA-1:0] din, input logic rd);
        fifo_WR = wr;
        fifo_IN = din;
        fifo_RD = rd;
        @(posedge clK);
        #1;
        fifo_WR = 1'b0;
        fifo_RD = 1'b0;
    endtask

    logic [DATA-1:0] wdat [100];

    initial begin
        for (int i = 0; i < 2**ADDR; i++) mem[i] = '0;
        rst_N   = 1'b0;
        fifo_WR = 1'b1;
        fifo_IN = 16'hDEAD;
        fifo_RD = 1'b0;
        #1;
        check("rst_empty", fifo_EMPTY, 1);
        check("rst_full", fifo_FULL, 0);
        check("rst_count", fifo_COUNT, 0);
        check("rst_ram_a_wr", ram_a_WR, 0);
        check("rst_valid", fifo_VALID, 0);
        check("ram_b_wr_tied", ram_b_WR, 0);
        check("ram_b_din_tied", ram_b_data_IN, 0);
        fifo_WR = 1'b0;
        repeat (2) @(posedge clK);
        #1;
        rst_N = 1'b1;

        // basic push 1..3 then pop, first push on first edge after reset release
        step(1, 16'h0001, 0);
        check("first_push_count", fifo_COUNT, 1);
        step(1, 16'h0002, 0);
        step(1, 16'h0003, 0);
        check("push3_count", fifo_COUNT, 3);
        check("push3_empty", fifo_EMPTY, 0);
        step(0, 0, 1);
        check("pop1_valid", fifo_VALID, 1);
        check("pop1_out", fifo_OUT, 16'h0001);
        step(0, 0, 1);
        check("pop2_out", fifo_OUT, 16'h0002);
        step(0, 0, 1);
        check("pop3_valid", fifo_VALID, 1);
        check("pop3_out", fifo_OUT, 16'h0003);
        check("pop3_empty", fifo_EMPTY, 1);
        step(0, 0, 0);
        check("idle_valid", fifo_VALID, 0);

        // pop while empty
        step(0, 0, 1);
        check("udf_valid", fifo_VALID, 0);
        check("udf_count", fifo_COUNT, 0);
        check("udf_rd_addr", ram_b_ADDR, 3);
        check("udf_wr_addr", ram_a_ADDR, 3);
`ifdef FIFO_CTRL_ERR_EN
        check("udf_flag", fifo_UDF, 1);
        check("udf_no_ovf", fifo_OVF, 0);
`endif

        // fill to full
        for (int i = 0; i < 32; i++) step(1, DATA'(16'h0100 + i), 0);
        check("full_flag", fifo_FULL, 1);
        check("full_count", fifo_COUNT, 32);
        fifo_WR = 1'b1;
        fifo_IN = 16'h01FF;
        #1;
        check("full_ram_a_wr", ram_a_WR, 0);
        step(1, 16'h01FF, 0);
        check("ovf_count", fifo_COUNT, 32);
`ifdef FIFO_CTRL_ERR_EN
        check("ovf_flag", fifo_OVF, 1);
`endif

        // push+pop at full: only the pop is taken
        step(1, 16'h01FE, 1);
        check("full_pp_count", fifo_COUNT, 31);
        check("full_pp_valid", fifo_VALID, 1);
        check("full_pp_out", fifo_OUT, 16'h0100);
        for (int i = 1; i <= 21; i++) begin
            step(0, 0, 1);
            check("drain_a_out", fifo_OUT, 32'h0100 + i);
        end
        check("cnt10", fifo_COUNT, 10);

        // push+pop mid-level
        step(1, 16'h0200, 1);
        check("mid_pp_count", fifo_COUNT, 10);
        check("mid_pp_out", fifo_OUT, 16'h0116);
        for (int i = 16'h0117; i <= 16'h011F; i++) begin
            step(0, 0, 1);
            check("drain_b_out", fifo_OUT, i);
        end
        step(0, 0, 1);
        check("drain_last_out", fifo_OUT, 16'h0200);
        check("drain_empty", fifo_EMPTY, 1);

        // push+pop at empty: only the push is taken
        step(1, 16'h0300, 1);
        check("empty_pp_count", fifo_COUNT, 1);
        check("empty_pp_valid", fifo_VALID, 0);
        step(0, 0, 1);
        check("empty_pp_out", fifo_OUT, 16'h0300);
        check("empty_pp_empty", fifo_EMPTY, 1);

        // 100 push/pop pairs, pointers wrap past 2**(ADDR+1)
        for (int i = 0; i < 100; i++) wdat[i] = DATA'(16'hA000 ^ (i * 37));
        step(1, wdat[0], 0);
        for (int i = 1; i < 100; i++) begin
            step(1, wdat[i], 1);
            check("wrap_valid", fifo_VALID, 1);
            check("wrap_out", fifo_OUT, wdat[i-1]);
        end
        check("wrap_count", fifo_COUNT, 1);
        step(0, 0, 1);
        check("wrap_last_out", fifo_OUT, wdat[99]);
        check("wrap_empty", fifo_EMPTY, 1);

        // reset mid-cycle with a pop in flight
        for (int i = 0; i < 7; i++) step(1, DATA'(16'h0700 + i), 0);
        check("pre_rst_count", fifo_COUNT, 7);
        fifo_RD = 1'b1;
        @(posedge clK);
        #3;
        rst_N = 1'b0;
        #1;
        check("mid_rst_valid", fifo_VALID, 0);
        check("mid_rst_count", fifo_COUNT, 0);
        check("mid_rst_empty", fifo_EMPTY, 1);
        check("mid_rst_full", fifo_FULL, 0);
        fifo_RD = 1'b0;
        #2;
        rst_N = 1'b1;
        step(0, 0, 0);
        check("post_rst_valid", fifo_VALID, 0);
        check("post_rst_count", fifo_COUNT, 0);
        step(1, 16'h0055, 0);
        check("post_rst_push", fifo_COUNT, 1);
        step(0, 0, 1);
        check("post_rst_out", fifo_OUT, 16'h0055);
        check("post_rst_rd_addr", ram_b_ADDR, 1);
`ifdef FIFO_CTRL_ERR_EN
        check("post_rst_ovf", fifo_OVF, 0);
        check("post_rst_udf", fifo_UDF, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
